// File: rtl/issue_drain.sv
// ============================================================================
// Module      : issue_drain
// Description : Instruction buffer that fills from one side, then drains its
//               valid entries lowest-slot-first through a ready/valid port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module issue_drain #(
    parameter int Instruction_word_size = 32,
    parameter int bs                    = 16,
    parameter int bs_bits               = (bs > 1) ? $clog2(bs) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_en,
    input  logic [bs_bits-1:0]               wr_index,
    input  logic [Instruction_word_size-1:0] wr_instr,
    input  logic                             proceed,
    input  logic                             issue_ready,
    output logic                             issue_valid,
    output logic [Instruction_word_size-1:0] issue_instr,
    output logic [bs_bits-1:0]               issue_index,
    output logic [bs-1:0]                    valid_entries,
    output logic                             busy,
    output logic                             wr_reject,
    output logic                             drain_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [bs_bits:0] BS_EXT = (bs_bits + 1)'(bs);

    state_t                           state_q, state_d;
    logic [bs-1:0]                    valid_q, valid_d;
    logic [Instruction_word_size-1:0] mem_q [bs];
    logic                             wr_reject_q, wr_reject_d;
    logic                             drain_done_q;
    logic                             store;
    logic                             eos;
    logic                             in_range;
    logic [bs_bits-1:0]               ptr;

    assign in_range = ({1'b0, wr_index} < BS_EXT);

    // Lowest-index valid slot; scanning downward lets the lowest hit win.
    always_comb begin
        ptr = '0;
        for (int i = bs - 1; i >= 0; i--) begin
            if (valid_q[i]) begin
                ptr = bs_bits'(i);
            end
        end
    end

    assign issue_valid   = (state_q == DRAIN) && (|valid_q);
    assign issue_index   = issue_valid ? ptr : '0;
    assign issue_instr   = issue_valid ? mem_q[ptr] : '0;
    assign valid_entries = valid_q;
    assign busy          = (state_q == DRAIN);
    assign wr_reject     = wr_reject_q;
    assign drain_done    = drain_done_q;

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        wr_reject_d = 1'b0;
        store       = 1'b0;
        eos         = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_en) begin
                    if (!in_range) begin
                        wr_reject_d = 1'b1;
                    end else if (wr_instr != '0) begin
                        store            = 1'b1;
                        valid_d[wr_index] = 1'b1;
                    end else begin
                        eos = 1'b1;
                    end
                end
                // The same-edge write is already folded into valid_d here.
                if (proceed || eos) begin
                    state_d = (valid_d != '0) ? DRAIN : DONE;
                end
            end
            DRAIN: begin
                wr_reject_d = wr_en;
                if (issue_valid && issue_ready) begin
                    valid_d[ptr] = 1'b0;
                end
                if (valid_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                wr_reject_d = wr_en;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            wr_reject_q  <= 1'b0;
            drain_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            wr_reject_q  <= wr_reject_d;
            drain_done_q <= (state_d == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst && store) begin
            mem_q[wr_index] <= wr_instr;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_issue_drain.sv
// ============================================================================
// Module      : tb_issue_drain
// Description : Directed self-checking bench for issue_drain.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_issue_drain;

    localparam int W  = 32;
    localparam int BS = 16;
    localparam int BB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [BB-1:0] wr_index;
    logic [W-1:0]  wr_instr;
    logic          proceed;
    logic          issue_ready;
    logic          issue_valid;
    logic [W-1:0]  issue_instr;
    logic [BB-1:0] issue_index;
    logic [BS-1:0] valid_entries;
    logic          busy;
    logic          wr_reject;
    logic          drain_done;

    int n_checks = 0;
    int n_fail   = 0;

    issue_drain #(
        .Instruction_word_size(W),
        .bs                   (BS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_index     (wr_index),
        .wr_instr     (wr_instr),
        .proceed      (proceed),
        .issue_ready  (issue_ready),
        .issue_valid  (issue_valid),
        .issue_instr  (issue_instr),
        .issue_index  (issue_index),
        .valid_entries(valid_entries),
        .busy         (busy),
        .wr_reject    (wr_reject),
        .drain_done   (drain_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input int idx, input logic [W-1:0] d);
        wr_en    = 1'b1;
        wr_index = BB'(idx);
        wr_instr = d;
        tick();
        wr_en    = 1'b0;
        wr_instr = '0;
        wr_index = '0;
    endtask

    task automatic expect_issue(input string tag, input int idx, input logic [W-1:0] d);
        check({tag, "_valid"}, 64'(issue_valid), 64'd1);
        check({tag, "_index"}, 64'(issue_index), 64'(idx));
        check({tag, "_instr"}, 64'(issue_instr), 64'(d));
    endtask

    initial begin
        int k;
        rst = 1'b0; wr_en = 1'b0; wr_index = '0; wr_instr = '0;
        proceed = 1'b0; issue_ready = 1'b0;
        tick();
        tick();
        check("rst_valid_entries", 64'(valid_entries), 64'd0);
        check("rst_issue_valid",   64'(issue_valid),   64'd0);
        check("rst_busy",          64'(busy),          64'd0);
        check("rst_wr_reject",     64'(wr_reject),     64'd0);
        check("rst_drain_done",    64'(drain_done),    64'd0);
        check("rst_issue_index",   64'(issue_index),   64'd0);
        rst = 1'b1;
        tick();

        // Basic three-entry drain, lowest slot first.
        write(5, 32'h11);
        write(0, 32'h22);
        write(9, 32'h33);
        check("t1_fill", 64'(valid_entries), 64'h0221);
        proceed = 1'b1; issue_ready = 1'b1;
        tick();
        proceed = 1'b0;
        check("t1_busy", 64'(busy), 64'd1);
        expect_issue("t1_i0", 0, 32'h22);
        tick();
        expect_issue("t1_i1", 5, 32'h11);
        tick();
        expect_issue("t1_i2", 9, 32'h33);
        tick();
        check("t1_done_valid", 64'(issue_valid),   64'd0);
        check("t1_done_pulse", 64'(drain_done),    64'd1);
        check("t1_done_busy",  64'(busy),          64'd0);
        check("t1_done_empty", 64'(valid_entries), 64'd0);
        tick();
        check("t1_done_clear", 64'(drain_done), 64'd0);
        issue_ready = 1'b0;

        // Full buffer, zero-word end marker, alternating ready.
        for (int i = 0; i < BS; i++) write(i, 32'h100 + i);
        wr_en = 1'b1; wr_index = 4'd0; wr_instr = '0;
        tick();
        wr_en = 1'b0;
        check("t2_enter_busy", 64'(busy),          64'd1);
        check("t2_full",       64'(valid_entries), 64'hffff);
        k = 0;
        for (int cyc = 0; cyc < 40 && k < BS; cyc++) begin
            issue_ready = (cyc % 2 == 0);
            expect_issue("t2_issue", k, 32'h100 + k);
            check("t2_busy", 64'(busy), 64'd1);
            if (issue_ready) k++;
            tick();
        end
        check("t2_count",      64'(k),          64'd16);
        check("t2_done_pulse", 64'(drain_done), 64'd1);
        check("t2_done_busy",  64'(busy),       64'd0);
        issue_ready = 1'b0;
        tick();

        // Overwrite of an existing slot.
        write(3, 32'hAA);
        write(3, 32'hBB);
        check("t3_fill", 64'(valid_entries), 64'h0008);
        proceed = 1'b1; issue_ready = 1'b1;
        tick();
        proceed = 1'b0;
        expect_issue("t3_i0", 3, 32'hBB);
        tick();
        check("t3_done_pulse", 64'(drain_done),  64'd1);
        check("t3_done_valid", 64'(issue_valid), 64'd0);
        issue_ready = 1'b0;
        tick();

        // Write during drain is rejected and does not disturb the sequence.
        write(1, 32'h10);
        write(2, 32'h20);
        proceed = 1'b1;
        tick();
        proceed = 1'b0;
        write(7, 32'h77);
        check("t4_reject",   64'(wr_reject),     64'd1);
        check("t4_valid",    64'(valid_entries), 64'h0006);
        expect_issue("t4_hold", 1, 32'h10);
        tick();
        check("t4_reject_clear", 64'(wr_reject), 64'd0);
        issue_ready = 1'b1;
        expect_issue("t4_i0", 1, 32'h10);
        tick();
        expect_issue("t4_i1", 2, 32'h20);
        tick();
        check("t4_done_pulse", 64'(drain_done),    64'd1);
        check("t4_done_empty", 64'(valid_entries), 64'd0);
        issue_ready = 1'b0;
        tick();

        // Proceed with an empty buffer.
        proceed = 1'b1;
        tick();
        proceed = 1'b0;
        check("t5_done_pulse", 64'(drain_done),  64'd1);
        check("t5_issue_valid",64'(issue_valid), 64'd0);
        check("t5_busy",       64'(busy),        64'd0);
        tick();
        check("t5_pulse_clear",64'(drain_done),  64'd0);
        check("t5_idle_valid", 64'(issue_valid), 64'd0);

        // Reset part-way through a drain.
        for (int i = 0; i < 4; i++) write(i, 32'h40 + i);
        proceed = 1'b1; issue_ready = 1'b1;
        tick();
        proceed = 1'b0;
        expect_issue("t6_i0", 0, 32'h40);
        tick();
        expect_issue("t6_i1", 1, 32'h41);
        tick();
        expect_issue("t6_i2", 2, 32'h42);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("t6_rst_valid",  64'(valid_entries), 64'd0);
        check("t6_rst_issue",  64'(issue_valid),   64'd0);
        check("t6_rst_done",   64'(drain_done),    64'd0);
        check("t6_rst_busy",   64'(busy),          64'd0);
        tick();
        check("t6_rst_done2",  64'(drain_done),    64'd0);
        write(6, 32'h66);
        proceed = 1'b1;
        tick();
        proceed = 1'b0;
        expect_issue("t6_new", 6, 32'h66);
        tick();
        check("t6_new_done", 64'(drain_done), 64'd1);
        issue_ready = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
